// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, redirect and forwarding control for the 3-stage core.
// Carries decoded control words D->X->W and keeps the cycle/instret counters.
module pipeline_ctrl #(
  parameter int CW_WIDTH  = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW_WIDTH-1:0]  cw_d,
  input  logic                 valid_d,
  input  logic [4:0]           rs1_d,
  input  logic [4:0]           rs2_d,
  input  logic [4:0]           rd_d,
  input  logic                 br_taken_x,
  output logic [CW_WIDTH-1:0]  cw_x,
  output logic [CW_WIDTH-1:0]  cw_w,
  output logic                 stall,
  output logic                 flush,
  output logic [1:0]           pc_sel,
  output logic                 fwd_a_x,
  output logic                 fwd_b_x,
  output logic                 fwd_a_d,
  output logic                 fwd_b_d,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_ALU   = 2'b01;
  localparam logic [1:0] PC_HOLD  = 2'b10;
  localparam logic [1:0] PC_RST   = 2'b11;

  localparam logic [1:0] CLS_BR   = 2'b01;

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  state_t     state, state_nx;

  logic       valid_x, valid_w;
  logic [4:0] rd_x, rs1_x, rs2_x, rd_w;

  logic       load_x;
  logic       hz_ld;
  logic       redir_x;
  logic       w_wr;
  logic       bubble_x;
  logic [1:0] cls_x;

  // hazard and redirect conditions from X state and D fields
  always_comb begin
    cls_x   = cw_x[15:14];
    load_x  = valid_x & cw_x[0] & (cw_x[13:12] == 2'b00);
    hz_ld   = load_x & (rd_x != 5'd0) & valid_d &
              ((rd_x == rs1_d) | (rd_x == rs2_d));
    redir_x = valid_x &
              (((cls_x == CLS_BR) & br_taken_x) | cls_x[1]);
  end

  // W-stage write bypass into X operands and D register reads
  always_comb begin
    w_wr    = valid_w & cw_w[0] & (rd_w != 5'd0);
    fwd_a_x = w_wr & (rd_w == rs1_x);
    fwd_b_x = w_wr & (rd_w == rs2_x);
    fwd_a_d = w_wr & (rd_w == rs1_d);
    fwd_b_d = w_wr & (rd_w == rs2_d);
  end

  // sequencing state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nx;
  end

  // next state and stall/flush/pc_sel; redirect outranks load-use
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    flush    = 1'b0;
    pc_sel   = PC_PLUS4;
    bubble_x = 1'b0;
    unique case (state)
      BOOT: begin
        state_nx = RUN;
        pc_sel   = PC_RST;
        bubble_x = 1'b1;
      end
      RUN: begin
        if (redir_x) begin
          flush    = 1'b1;
          pc_sel   = PC_ALU;
          bubble_x = 1'b1;
        end else if (hz_ld) begin
          stall    = 1'b1;
          pc_sel   = PC_HOLD;
          bubble_x = 1'b1;
        end
      end
    endcase
  end

  // X and W stage control registers; W always advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cw_x    <= '0;
      valid_x <= 1'b0;
      rd_x    <= '0;
      rs1_x   <= '0;
      rs2_x   <= '0;
      cw_w    <= '0;
      valid_w <= 1'b0;
      rd_w    <= '0;
    end else begin
      cw_w    <= cw_x;
      valid_w <= valid_x;
      rd_w    <= rd_x;
      if (bubble_x) begin
        cw_x    <= '0;
        valid_x <= 1'b0;
        rd_x    <= '0;
        rs1_x   <= '0;
        rs2_x   <= '0;
      end else begin
        cw_x    <= valid_d ? cw_d : '0;
        valid_x <= valid_d;
        rd_x    <= rd_d;
        rs1_x   <= rs1_d;
        rs2_x   <= rs2_d;
      end
    end
  end

  // cycle count in RUN, instret on every real instruction leaving W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state == RUN) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (valid_w) instret_cnt <= instret_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
